packer_k_to_n_stream: RTL and testbench

- Parametrised stream packer that gathers FACTOR consecutive IN_WIDTH-bit words into one FACTOR*IN_WIDTH-bit word.
- Both sides use a valid/ready handshake with backpressure.
- Supports partial packets, closed early by in_last and flagged with a per-lane keep mask.
- Sits between narrow producers (byte/sample streams) and wide datapaths or memory write ports.

---
 rtl/packer_k_to_n_stream.sv | 135 +++++++++++++
 tb/tb_packer_k_to_n_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packer_k_to_n_stream.sv
// packer_k_to_n_stream: gathers FACTOR narrow words into one wide word.
// Optional timeout flush of partial packets: define PACKER_TIMEOUT_FLUSH_EN.
module packer_k_to_n_stream #(
    parameter int FACTOR    = 4,
    parameter int IN_WIDTH  = 8,
    parameter int LSB_FIRST = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FACTOR*IN_WIDTH-1:0]   out_data,
    output logic [FACTOR-1:0]            out_keep,
    output logic                         out_last,
    output logic                         out_flushed
);

    localparam int W  = FACTOR * IN_WIDTH;
    localparam int CW = $clog2(FACTOR) + 1;

    if (FACTOR < 1 || FACTOR > 64) begin : g_bad_factor
        $error("packer_k_to_n_stream: FACTOR out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("packer_k_to_n_stream: TIMEOUT out of range");
    end

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     lane;
    logic [W-1:0]      acc;
    logic [W-1:0]      acc_nxt;
    logic [FACTOR-1:0] acc_keep;
    logic [FACTOR-1:0] keep_nxt;
    logic              accept;
    logic              xfer;
    logic              complete;
    logic              flush;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign complete = accept & ((cnt == CW'(FACTOR - 1)) | in_last);
    assign lane     = (LSB_FIRST != 0) ? cnt : CW'(FACTOR - 1) - cnt;

    // Merge the incoming word into its lane of the accumulator.
    always_comb begin
        acc_nxt  = acc;
        keep_nxt = acc_keep;
        for (int k = 0; k < FACTOR; k++) begin
            if (lane == CW'(k)) begin
                acc_nxt[k*IN_WIDTH +: IN_WIDTH] = in_data;
                keep_nxt[k]                     = 1'b1;
            end
        end
    end

`ifdef PACKER_TIMEOUT_FLUSH_EN
    logic [15:0] idle_cnt;
    logic        flushed_q;

    assign flush = (cnt != '0) & ~accept & in_ready
                 & (idle_cnt == 16'(TIMEOUT));
    assign out_flushed = flushed_q;

    // Count idle cycles while a partial packet waits; saturate at the limit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
        end else if (accept || cnt == '0 || flush) begin
            idle_cnt <= '0;
        end else if (idle_cnt != 16'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // Mark output words that came from a timeout rather than a real beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flushed_q <= 1'b0;
        end else if (complete) begin
            flushed_q <= 1'b0;
        end else if (flush) begin
            flushed_q <= 1'b1;
        end
    end
`else
    assign flush       = 1'b0;
    assign out_flushed = 1'b0;
`endif

    // Output register: load on completion or flush, drop valid on transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= acc_nxt;
            out_keep  <= keep_nxt;
            out_last  <= in_last;
        end else if (flush) begin
            out_valid <= 1'b1;
            out_data  <= acc;
            out_keep  <= acc_keep;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator and lane counter; cleared whenever a word is handed off.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else if (complete || flush) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            cnt      <= cnt + CW'(1);
            acc      <= acc_nxt;
            acc_keep <= keep_nxt;
        end
    end

endmodule

// File: tb/tb_packer_k_to_n_stream.sv
// tb_packer_k_to_n_stream: table vectors plus scoreboard for the packer.
// LSB-first and MSB-first instances share one stimulus stream.
module tb_packer_k_to_n_stream;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_last, out_flushed;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        in_ready_m, out_valid_m, out_last_m, out_flushed_m;
    logic [31:0] out_data_m;
    logic [3:0]  out_keep_m;

    always #5 clk = ~clk;

    packer_k_to_n_stream #(
        .FACTOR(4), .IN_WIDTH(8), .LSB_FIRST(1), .TIMEOUT(16)
    ) u_lsb (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .out_flushed(out_flushed)
    );

    packer_k_to_n_stream #(
        .FACTOR(4), .IN_WIDTH(8), .LSB_FIRST(0), .TIMEOUT(16)
    ) u_msb (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_m), .out_ready(out_ready),
        .out_data(out_data_m), .out_keep(out_keep_m),
        .out_last(out_last_m), .out_flushed(out_flushed_m)
    );

    typedef struct {
        logic [31:0] d_lsb;
        logic [31:0] d_msb;
        logic [3:0]  keep;
        logic [3:0]  keep_m;
        logic        last;
        logic        flushed;
    } exp_t;

    typedef struct {
        int          n;
        logic [31:0] w;
        logic        last;
        logic [31:0] d_lsb;
        logic [31:0] d_msb;
        logic [3:0]  keep;
        logic [3:0]  keep_m;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[6];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] w,
                                input logic l, input logic [31:0] dl,
                                input logic [31:0] dm, input logic [3:0] k,
                                input logic [3:0] km);
        vec_t v;
        v.n = n; v.w = w; v.last = l;
        v.d_lsb = dl; v.d_msb = dm; v.keep = k; v.keep_m = km;
        return v;
    endfunction

    // Scoreboard: compare every transferred word against the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rstn && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none", out_data);
            end else begin
                e = sbq.pop_front();
                check("sb_data", 64'(out_data), 64'(e.d_lsb));
                check("sb_data_msb", 64'(out_data_m), 64'(e.d_msb));
                check("sb_keep", 64'(out_keep), 64'(e.keep));
                check("sb_keep_msb", 64'(out_keep_m), 64'(e.keep_m));
                check("sb_last", 64'(out_last), 64'(e.last));
                check("sb_flushed", 64'(out_flushed), 64'(e.flushed));
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v, input logic flushed);
        exp_t e;
        e.d_lsb = v.d_lsb; e.d_msb = v.d_msb;
        e.keep = v.keep; e.keep_m = v.keep_m;
        e.last = v.last; e.flushed = flushed;
        for (int j = 0; j < v.n; j++) begin
            if (j == v.n - 1) sbq.push_back(e);
            send_word(v.w[j*8 +: 8], v.last && (j == v.n - 1));
        end
    endtask

    initial begin
        vt[0] = mk(4, 32'h44332211, 1'b0, 32'h44332211, 32'h11223344,
                   4'b1111, 4'b1111);
        vt[1] = mk(2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 32'hAABB0000,
                   4'b0011, 4'b1100);
        vt[2] = mk(4, 32'h04030201, 1'b1, 32'h04030201, 32'h01020304,
                   4'b1111, 4'b1111);
        vt[3] = mk(1, 32'h000000C3, 1'b1, 32'h000000C3, 32'hC3000000,
                   4'b0001, 4'b1000);
        vt[4] = mk(1, 32'h0000003C, 1'b1, 32'h0000003C, 32'h3C000000,
                   4'b0001, 4'b1000);
        vt[5] = mk(3, 32'h00302010, 1'b0, 32'h00302010, 32'h10203000,
                   4'b0111, 4'b1110);
        vt[5].last = 1'b1;

        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_flushed", 64'(out_flushed), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            send_pkt(vt[i], 1'b0);
            check("latency_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send_pkt(vt[0], 1'b0);
        fork
            send_pkt(mk(4, 32'h88776655, 1'b0, 32'h88776655, 32'h55667788,
                        4'b1111, 4'b1111), 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_valid", 64'(out_valid), 64'd1);
                    check("bp_hold", 64'(out_data), 64'h44332211);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_drain", 64'(sbq.size()), 64'd0);

        send_word(8'hDE, 1'b0);
        send_word(8'hAD, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_keep", 64'(out_keep), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(mk(4, 32'h04030201, 1'b0, 32'h04030201, 32'h01020304,
                    4'b1111, 4'b1111), 1'b0);

`ifdef PACKER_TIMEOUT_FLUSH_EN
        begin
            int gap;
            gap = 0;
            send_pkt(mk(1, 32'h5A, 1'b0, 32'h0000005A, 32'h5A000000,
                        4'b0001, 4'b1000), 1'b1);
            while (!out_valid && gap < 60) begin
                @(posedge clk);
                #1;
                gap++;
            end
            check("flush_gap", 64'(gap), 64'd17);
            repeat (2) @(posedge clk);
            #1;
            send_word(8'h5A, 1'b0);
            repeat (16) @(posedge clk);
            #1;
            sbq.push_back('{32'h00006B5A, 32'h5A6B0000, 4'b0011, 4'b1100,
                            1'b1, 1'b0});
            send_word(8'h6B, 1'b1);
            check("cancel_valid", 64'(out_valid), 64'd1);
            check("cancel_flushed", 64'(out_flushed), 64'd0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_final_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
